// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the two-read / one-write register file:
//   - clr_state_e      : states of the sequenced clear engine
//   - DEFAULT_DATA_W   : default register width in bits
//   - DEFAULT_NUM_REGS : default register count
//   - addrWidth()      : address width for a given register count, never
//                        narrower than one bit
// ---------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

   localparam int DEFAULT_DATA_W   = 8;
   localparam int DEFAULT_NUM_REGS = 8;

   // A two-entry file still needs one address bit, so clamp the result at 1.
   function automatic int addrWidth(input int numRegs);
      return (numRegs <= 2) ? 1 : $clog2(numRegs);
   endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// ---------------------------------------------------------------------------
// regfile_clear_fsm
// Walks a pointer across the register file, one register per clock, to
// zero every writable register. It then holds a one-cycle DONE state
// before returning to IDLE.
// Ports:
//   clk_i     in   clock, rising edge
//   rst_ni    in   synchronous active-low reset
//   clr_req_i in   start a clear sequence (only honoured in IDLE)
//   busy      out  high in CLEAR and DONE
//   done      out  high only in DONE
//   clr_we    out  zero register clr_idx at the next edge
//   clr_idx   out  register being cleared this cycle
// ---------------------------------------------------------------------------
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int ZERO_REG = 1,
   parameter int AW       = addrWidth(NUM_REGS)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_req_i,
   output logic          busy,
   output logic          done,
   output logic          clr_we,
   output logic [AW-1:0] clr_idx
);

   // Register 0 is skipped when it is hardwired to zero.
   localparam logic [AW-1:0] FIRST_IDX = (ZERO_REG != 0) ? AW'(1) : AW'(0);
   localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;

   // State and pointer registers. Reset wins over everything, including a
   // clear that is already in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state logic. In IDLE a request loads the first index to clear.
   // CLEAR then advances one register per edge until it reaches the last
   // register. DONE always lasts exactly one cycle, and requests seen
   // while busy are ignored.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (clr_req_i) begin
               state_d = CLEAR;
               ptr_d   = FIRST_IDX;
            end
         end
         CLEAR: begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == LAST_IDX) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status outputs decoded straight from the current state.
   always_comb begin
      busy    = (state_q != IDLE);
      done    = (state_q == DONE);
      clr_we  = (state_q == CLEAR);
      clr_idx = ptr_q;
   end

endmodule

// File: rtl/register_file_2r1w.sv
// ---------------------------------------------------------------------------
// register_file_2r1w
// Register file with two combinational read ports and one write port.
// A write is visible on a read port in the same cycle it is accepted.
// An optional hardwired-zero register 0 is supported, as is a sequenced
// clear of the whole file.
// Ports:
//   CLK        in   clock, rising edge
//   RESET_N    in   synchronous active-low reset
//   WR_EN      in   write strobe (honoured only when no clear is running)
//   WR_ADDR    in   write index
//   WR_DATA    in   write data
//   RD_ADDR_A  in   read port A index
//   RD_DATA_A  out  read port A data
//   RD_ADDR_B  in   read port B index
//   RD_DATA_B  out  read port B data
//   CLR_REQ    in   request a sequenced clear
//   CLR_BUSY   out  clear in progress
//   CLR_DONE   out  one-cycle pulse at clear completion
//   TEST_OUT   out  all registers, register i at [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module register_file_2r1w
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int ZERO_REG = 1,
   localparam int AW      = addrWidth(NUM_REGS)
) (
   input  logic                       CLK,
   input  logic                       RESET_N,
   input  logic                       WR_EN,
   input  logic [AW-1:0]              WR_ADDR,
   input  logic [DATA_W-1:0]          WR_DATA,
   input  logic [AW-1:0]              RD_ADDR_A,
   output logic [DATA_W-1:0]          RD_DATA_A,
   input  logic [AW-1:0]              RD_ADDR_B,
   output logic [DATA_W-1:0]          RD_DATA_B,
   input  logic                       CLR_REQ,
   output logic                       CLR_BUSY,
   output logic                       CLR_DONE,
   output logic [NUM_REGS*DATA_W-1:0] TEST_OUT
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];

   logic          clrBusy;
   logic          clrDone;
   logic          clrWe;
   logic [AW-1:0] clrIdx;
   logic          wrAccept;

   regfile_clear_fsm #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_clear (
      .clk_i     (CLK),
      .rst_ni    (RESET_N),
      .clr_req_i (CLR_REQ),
      .busy      (clrBusy),
      .done      (clrDone),
      .clr_we    (clrWe),
      .clr_idx   (clrIdx)
   );

   // An address names real storage only if it is inside the file and is
   // not the hardwired-zero register. The same rule gates both writes
   // and reads.
   function automatic logic addrLive(input logic [AW-1:0] addr);
      return (int'(addr) < NUM_REGS) && !((ZERO_REG != 0) && (addr == '0));
   endfunction

   // A read returns the incoming write data when that write is accepted
   // this cycle to the same address. Otherwise it returns the stored value.
   // Dead addresses always read as zero.
   function automatic logic [DATA_W-1:0] readPort(input logic [AW-1:0] addr);
      logic [DATA_W-1:0] data;
      data = '0;
      if (addrLive(addr)) begin
         if (wrAccept && (addr == WR_ADDR)) begin
            data = WR_DATA;
         end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (addr == AW'(i)) begin
                  data = regs_q[i];
               end
            end
         end
      end
      return data;
   endfunction

   // Writes are only taken while the clear engine is idle. Writes that
   // arrive during a clear are dropped, not stalled.
   always_comb begin
      wrAccept = WR_EN && !clrBusy && addrLive(WR_ADDR);
   end

   // Next contents of the file. A user write and a clear write can never
   // happen together, because writes are blocked while busy.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wrAccept && (WR_ADDR == AW'(i))) begin
            regs_d[i] = WR_DATA;
         end
         if (clrWe && (clrIdx == AW'(i))) begin
            regs_d[i] = '0;
         end
      end
      if (ZERO_REG != 0) begin
         regs_d[0] = '0;
      end
   end

   // Storage. Reset clears every register immediately, even mid-sequence.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read ports, status and flattened debug view.
   always_comb begin
      RD_DATA_A = readPort(RD_ADDR_A);
      RD_DATA_B = readPort(RD_ADDR_B);
      CLR_BUSY  = clrBusy;
      CLR_DONE  = clrDone;
      TEST_OUT  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         TEST_OUT[i*DATA_W +: DATA_W] = regs_q[i];
      end
   end

endmodule

// File: tb/tb_register_file_2r1w.sv
// ---------------------------------------------------------------------------
// tb_register_file_2r1w
// Drives three register files with shared stimulus:
//   k=0  defaults (8 regs, r0 hardwired)
//   k=1  8 regs, r0 writable
//   k=2  6 regs, r0 hardwired
// Each instance is checked against an array-based reference model.
// ---------------------------------------------------------------------------
module tb_register_file_2r1w;

   logic       clk;
   logic       resetN;
   logic       wrEn;
   logic [2:0] wrAddr;
   logic [7:0] wrData;
   logic [2:0] rdAddrA;
   logic [2:0] rdAddrB;
   logic       clrReq;

   logic [7:0]  rdA [3];
   logic [7:0]  rdB [3];
   logic        busy [3];
   logic        done [3];
   logic [63:0] testOut0;
   logic [63:0] testOut1;
   logic [47:0] testOut2;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int         numR [3] = '{8, 8, 6};
   bit         zr   [3] = '{1'b1, 1'b0, 1'b1};
   logic [7:0] mregs [3][8];
   bit         mclearing [3];
   bit         mdone [3];
   int         mIdx [3];

   register_file_2r1w #(.DATA_W(8), .NUM_REGS(8), .ZERO_REG(1)) dut0 (
      .CLK(clk), .RESET_N(resetN), .WR_EN(wrEn), .WR_ADDR(wrAddr), .WR_DATA(wrData),
      .RD_ADDR_A(rdAddrA), .RD_DATA_A(rdA[0]), .RD_ADDR_B(rdAddrB), .RD_DATA_B(rdB[0]),
      .CLR_REQ(clrReq), .CLR_BUSY(busy[0]), .CLR_DONE(done[0]), .TEST_OUT(testOut0));

   register_file_2r1w #(.DATA_W(8), .NUM_REGS(8), .ZERO_REG(0)) dut1 (
      .CLK(clk), .RESET_N(resetN), .WR_EN(wrEn), .WR_ADDR(wrAddr), .WR_DATA(wrData),
      .RD_ADDR_A(rdAddrA), .RD_DATA_A(rdA[1]), .RD_ADDR_B(rdAddrB), .RD_DATA_B(rdB[1]),
      .CLR_REQ(clrReq), .CLR_BUSY(busy[1]), .CLR_DONE(done[1]), .TEST_OUT(testOut1));

   register_file_2r1w #(.DATA_W(8), .NUM_REGS(6), .ZERO_REG(1)) dut2 (
      .CLK(clk), .RESET_N(resetN), .WR_EN(wrEn), .WR_ADDR(wrAddr), .WR_DATA(wrData),
      .RD_ADDR_A(rdAddrA), .RD_DATA_A(rdA[2]), .RD_ADDR_B(rdAddrB), .RD_DATA_B(rdB[2]),
      .CLR_REQ(clrReq), .CLR_BUSY(busy[2]), .CLR_DONE(done[2]), .TEST_OUT(testOut2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flattened register view of instance k, widened to 64 bits
   function automatic logic [63:0] dutFlat(int k);
      case (k)
         0:       return testOut0;
         1:       return testOut1;
         default: return {16'h0000, testOut2};
      endcase
   endfunction

   function automatic bit modelBusy(int k);
      return mclearing[k] || mdone[k];
   endfunction

   function automatic bit modelWriteOk(int k);
      return wrEn && !modelBusy(k) && (int'(wrAddr) < numR[k]) &&
             !(zr[k] && (wrAddr == 3'd0));
   endfunction

   function automatic logic [7:0] modelRead(int k, logic [2:0] addr);
      if ((int'(addr) >= numR[k]) || (zr[k] && (addr == 3'd0))) return 8'h00;
      if (modelWriteOk(k) && (addr == wrAddr)) return wrData;
      return mregs[k][addr];
   endfunction

   function automatic logic [63:0] modelFlat(int k);
      logic [63:0] f;
      f = '0;
      for (int i = 0; i < numR[k]; i++) f[i*8 +: 8] = mregs[k][i];
      return f;
   endfunction

   // Advance the model by one rising edge, using the inputs present at that edge
   task automatic modelStep();
      for (int k = 0; k < 3; k++) begin
         if (!resetN) begin
            for (int i = 0; i < 8; i++) mregs[k][i] = 8'h00;
            mclearing[k] = 0;
            mdone[k]     = 0;
            mIdx[k]      = 0;
         end else if (mclearing[k]) begin
            mregs[k][mIdx[k]] = 8'h00;
            if (mIdx[k] == numR[k] - 1) begin
               mclearing[k] = 0;
               mdone[k]     = 1;
            end else begin
               mIdx[k]++;
            end
         end else if (mdone[k]) begin
            mdone[k] = 0;
         end else begin
            if (modelWriteOk(k)) mregs[k][wrAddr] = wrData;
            if (clrReq) begin
               mclearing[k] = 1;
               mIdx[k]      = zr[k] ? 1 : 0;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic idleInputs();
      wrEn = 0; wrAddr = 0; wrData = 0; rdAddrA = 0; rdAddrB = 0; clrReq = 0;
   endtask

   task automatic test_reset();
      idleInputs();
      resetN = 0;
      tick();
      tick();
      resetN = 1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (busy[k] !== 1'b0 || done[k] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_status k=%0d busy=%b done=%b required 0/0", k, busy[k], done[k]);
         end
         checks++;
         if (dutFlat(k) !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_testout k=%0d got=%h required 0", k, dutFlat(k));
         end
         checks++;
         if (rdA[k] !== 8'h00 || rdB[k] !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_reads k=%0d a=%h b=%h required 00", k, rdA[k], rdB[k]);
         end
      end
   endtask

   task automatic test_write_read();
      wrEn = 1; wrAddr = 3; wrData = 8'hA5;
      tick();
      wrEn = 0; rdAddrA = 3; rdAddrB = 3;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rdA[k] !== 8'hA5 || rdB[k] !== 8'hA5) begin
            failures++;
            $display("[TB] FAIL write_read k=%0d a=%h b=%h required a5", k, rdA[k], rdB[k]);
         end
      end
   endtask

   task automatic test_bypass();
      wrEn = 1; wrAddr = 5; wrData = 8'h3C; rdAddrA = 5; rdAddrB = 3;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (rdA[k] !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL bypass k=%0d got=%h required 3c", k, rdA[k]);
         end
      end
      tick();
      wrEn = 0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dutFlat(k) !== modelFlat(k) || dutFlat(k)[47:40] !== 8'h3C) begin
            failures++;
            $display("[TB] FAIL bypass_stored k=%0d got=%h required %h", k, dutFlat(k), modelFlat(k));
         end
      end
   endtask

   task automatic test_zero_reg();
      logic [7:0] want;
      wrEn = 1; wrAddr = 0; wrData = 8'hFF; rdAddrA = 0;
      #1;
      for (int k = 0; k < 3; k++) begin
         want = zr[k] ? 8'h00 : 8'hFF;
         checks++;
         if (rdA[k] !== want) begin
            failures++;
            $display("[TB] FAIL zero_reg_bypass k=%0d got=%h required %h", k, rdA[k], want);
         end
      end
      tick();
      wrEn = 0;
      #1;
      for (int k = 0; k < 3; k++) begin
         want = zr[k] ? 8'h00 : 8'hFF;
         checks++;
         if (rdA[k] !== want || dutFlat(k)[7:0] !== want) begin
            failures++;
            $display("[TB] FAIL zero_reg_stored k=%0d rd=%h reg0=%h required %h", k, rdA[k], dutFlat(k)[7:0], want);
         end
      end
   endtask

   task automatic test_out_of_range();
      wrEn = 1; wrAddr = 7; wrData = 8'h99; rdAddrA = 7; rdAddrB = 6;
      #1;
      checks++;
      if (rdA[2] !== 8'h00 || rdB[2] !== 8'h00) begin
         failures++;
         $display("[TB] FAIL oor_read a=%h b=%h required 00", rdA[2], rdB[2]);
      end
      tick();
      wrEn = 0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (dutFlat(k) !== modelFlat(k)) begin
            failures++;
            $display("[TB] FAIL oor_write k=%0d got=%h required %h", k, dutFlat(k), modelFlat(k));
         end
      end
      checks++;
      if (rdA[0] !== 8'h99 || rdB[2] !== 8'h00) begin
         failures++;
         $display("[TB] FAIL oor_after r7_k0=%h r6_k2=%h required 99/00", rdA[0], rdB[2]);
      end
   endtask

   // Runs a clear that has already been started, counting busy cycles per instance
   task automatic runClear(input bit midWrite);
      int cnt [3];
      int doneAt [3];
      int want;
      for (int k = 0; k < 3; k++) begin cnt[k] = 0; doneAt[k] = 0; end
      for (int cyc = 0; cyc < 14; cyc++) begin
         wrEn = midWrite && (cyc == 2); wrAddr = 2; wrData = 8'h5A;
         rdAddrA = 3'($urandom_range(0, 7)); rdAddrB = 2;
         #1;
         for (int k = 0; k < 3; k++) begin
            if (busy[k] === 1'b1) cnt[k]++;
            if (done[k] === 1'b1) doneAt[k] = cnt[k];
            checks++;
            if (busy[k] !== modelBusy(k) || done[k] !== mdone[k] || rdA[k] !== modelRead(k, rdAddrA)) begin
               failures++;
               $display("[TB] FAIL clear_cycle k=%0d cyc=%0d busy=%b done=%b rd=%h required %b/%b/%h",
                        k, cyc, busy[k], done[k], rdA[k], modelBusy(k), mdone[k], modelRead(k, rdAddrA));
            end
         end
         tick();
      end
      wrEn = 0;
      for (int k = 0; k < 3; k++) begin
         want = numR[k] - (zr[k] ? 1 : 0) + 1;
         checks++;
         if (cnt[k] != want || doneAt[k] != want) begin
            failures++;
            $display("[TB] FAIL clear_length k=%0d busy=%0d doneAt=%0d required %0d", k, cnt[k], doneAt[k], want);
         end
         checks++;
         if (dutFlat(k) !== 64'h0) begin
            failures++;
            $display("[TB] FAIL clear_result k=%0d got=%h required 0", k, dutFlat(k));
         end
      end
   endtask

   task automatic test_clear();
      for (int i = 1; i < 8; i++) begin
         wrEn = 1; wrAddr = 3'(i); wrData = 8'(i * 8'h11);
         tick();
      end
      wrEn = 0;
      #1;
      checks++;
      if (testOut0 !== 64'h7766554433221100) begin
         failures++;
         $display("[TB] FAIL fill got=%h required 7766554433221100", testOut0);
      end
      clrReq = 1;
      tick();
      clrReq = 0;
      runClear(1'b1);
   endtask

   task automatic test_reset_mid_clear();
      wrEn = 1; wrAddr = 4; wrData = 8'h44;
      tick();
      wrAddr = 1; wrData = 8'h12;
      tick();
      wrEn = 0; clrReq = 1;
      tick();
      clrReq = 0;
      tick();
      tick();
      resetN = 0;
      tick();
      resetN = 1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (busy[k] !== 1'b0 || done[k] !== 1'b0 || dutFlat(k) !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid_clear k=%0d busy=%b done=%b regs=%h required 0/0/0",
                     k, busy[k], done[k], dutFlat(k));
         end
      end
      wrEn = 1; wrAddr = 3; wrData = 8'hC3;
      tick();
      wrEn = 0; clrReq = 1;
      tick();
      clrReq = 0;
      runClear(1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         resetN  = ($urandom_range(0, 60) != 0);
         wrEn    = $urandom_range(0, 1);
         wrAddr  = 3'($urandom_range(0, 7));
         wrData  = 8'($urandom);
         rdAddrA = 3'($urandom_range(0, 7));
         rdAddrB = ($urandom_range(0, 3) == 0) ? wrAddr : 3'($urandom_range(0, 7));
         clrReq  = ($urandom_range(0, 20) == 0);
         #1;
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdA[k] !== modelRead(k, rdAddrA) || rdB[k] !== modelRead(k, rdAddrB)) begin
               failures++;
               $display("[TB] FAIL random_read n=%0d k=%0d a=%h b=%h required %h/%h",
                        n, k, rdA[k], rdB[k], modelRead(k, rdAddrA), modelRead(k, rdAddrB));
            end
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy[k] !== modelBusy(k) || done[k] !== mdone[k] || dutFlat(k) !== modelFlat(k)) begin
               failures++;
               $display("[TB] FAIL random_state n=%0d k=%0d busy=%b done=%b regs=%h required %b/%b/%h",
                        n, k, busy[k], done[k], dutFlat(k), modelBusy(k), mdone[k], modelFlat(k));
            end
         end
      end
      resetN = 1;
      idleInputs();
   endtask

   initial begin
      resetN = 0;
      idleInputs();
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_reg();
      test_out_of_range();
      test_clear();
      test_reset_mid_clear();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/register_file_2r1w.md
REGISTER_FILE_2R1W -- requirements
Module: register_file_2r1w

Interface
REQ-001 Parameter DATA_W, default 8: data width per register, bits; legal range >= 1.
REQ-002 Parameter NUM_REGS, default 8: register count; legal range 2..256; need not be a power of two.
REQ-003 Parameter ZERO_REG, default 1: 1 means register 0 is hardwired to zero; 0 means register 0 is writable.
REQ-004 Derived constant AW = max(1, clog2(NUM_REGS)): address width.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 CLK  in  1  clock; all state changes on its rising edge.
REQ-007 RESET_N  in  1  synchronous active-low reset.
REQ-008 WR_EN  in  1  write strobe.
REQ-009 WR_ADDR  in  AW  write index.
REQ-010 WR_DATA  in  DATA_W  write data.
REQ-011 RD_ADDR_A  in  AW  read port A index.
REQ-012 RD_DATA_A  out  DATA_W  read port A data.
REQ-013 RD_ADDR_B  in  AW  read port B index.
REQ-014 RD_DATA_B  out  DATA_W  read port B data.
REQ-015 CLR_REQ  in  1  request a sequenced clear of all registers.
REQ-016 CLR_BUSY  out  1  clear sequence in progress.
REQ-017 CLR_DONE  out  1  one-cycle pulse marking clear completion.
REQ-018 TEST_OUT  out  NUM_REGS*DATA_W  flat view of all registers; register i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-019 Writes SHALL occur at the rising edge when WR_EN=1 and the FSM is IDLE. They SHALL be dropped when WR_ADDR >= NUM_REGS, or when WR_ADDR=0 and ZERO_REG=1.
REQ-020 Reads SHALL be combinational (0-cycle latency). Both ports are independent; same-address reads on A and B SHALL be legal.
REQ-021 Write-through bypass: if a write is accepted this cycle and RD_ADDR_x = WR_ADDR, RD_DATA_x SHALL equal WR_DATA.
REQ-022 RD_ADDR_x >= NUM_REGS, or 0 with ZERO_REG=1, SHALL return all-zeros. Bypass SHALL never apply in these cases.
REQ-023 The clear FSM SHALL have states IDLE, CLEAR and DONE.
REQ-024 IDLE -> CLEAR: CLR_REQ=1 sampled at an edge in IDLE. A write accepted at that same edge SHALL still complete. At that edge, the clear pointer SHALL load first_idx = ZERO_REG ? 1 : 0.
REQ-025 In CLEAR, each edge SHALL zero register[ptr] and increment ptr.
REQ-026 CLEAR -> DONE: at the edge that clears register NUM_REGS-1.
REQ-027 DONE -> IDLE: unconditionally after one cycle.
REQ-028 CLR_BUSY SHALL be 1 in CLEAR and DONE. CLR_DONE SHALL be 1 only in DONE.
REQ-029 Writes arriving in CLEAR or DONE SHALL be dropped; no stalling, no queuing.
REQ-030 CLR_REQ SHALL be ignored in CLEAR and DONE. A CLR_REQ held high through DONE SHALL start a new sequence from IDLE.
REQ-031 Reads during a clear SHALL return current stored contents; no bypass of clear writes.
REQ-032 Clear duration: NUM_REGS - first_idx CLEAR cycles, then 1 DONE cycle.

Reset
REQ-033 RESET_N=0 at an edge SHALL zero all registers, force state IDLE and set the pointer to 0. It SHALL take priority over writes and the clear, including mid-clear.
REQ-034 After reset: CLR_BUSY=0, CLR_DONE=0, TEST_OUT=0. RD_DATA_A and RD_DATA_B SHALL be 0 absent an accepted write.

Structure
REQ-035 Package regfile_pkg SHALL hold the clear-state enum (IDLE, CLEAR, DONE) and the default values of DATA_W and NUM_REGS.
REQ-036 The clear FSM and pointer SHALL live in sub-module regfile_clear_fsm. Its outputs are busy, done, clr_we and clr_idx.
REQ-037 Storage, write decode and the read muxes SHALL live in the top module.

Verification
REQ-038 Defaults; write 0xA5 to r3; read A=3, B=3 next cycle -> both read 0xA5.
REQ-039 WR_EN=1, WR_ADDR=5, WR_DATA=0x3C, RD_ADDR_A=5 in the same cycle -> RD_DATA_A=0x3C before the edge, and r5=0x3C after it.
REQ-040 ZERO_REG=1: write 0xFF to r0 -> RD_DATA_A(0)=0 and TEST_OUT[7:0]=0. ZERO_REG=0: same write -> reads 0xFF.
REQ-041 Fill r1..r7 with 0x11..0x77; pulse CLR_REQ -> CLR_BUSY=1 for 8 cycles; CLR_DONE high on the 8th cycle; TEST_OUT=0 afterwards. A write to r2 mid-clear -> r2 stays 0.
REQ-042 NUM_REGS=6: write 0x99 to address 7 -> no change to TEST_OUT; reading address 6 -> 0.
REQ-043 RESET_N=0 on the 3rd cycle of CLEAR -> next cycle CLR_BUSY=0, CLR_DONE=0, all registers 0. A CLR_REQ after reset completes normally.
